// File: rtl/fifo_mport_if.sv
// fifo_mport_if: push/pop handshake bus of the multi-port FIFO
interface fifo_mport_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int HEADS = 2,
  parameter int TAILS = 2
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [HEADS-1:0] push;
  logic [HEADS-1:0][WIDTH-1:0] dinp;
  logic [HEADS-1:0] push_rdy;
  logic [TAILS-1:0] pop;
  logic [TAILS-1:0][WIDTH-1:0] doup;
  logic [TAILS-1:0] doup_vld;
  logic flush;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic almost_full;
  logic almost_empty;
  logic ovf;
  logic unf;
  modport master (
    output push, dinp, pop, flush,
    input push_rdy, doup, doup_vld, count, free, almost_full, almost_empty, ovf, unf
  );
  modport slave (
    input push, dinp, pop, flush,
    output push_rdy, doup, doup_vld, count, free, almost_full, almost_empty, ovf, unf
  );
endinterface

// File: rtl/fifo_mport.sv
// fifo_mport: FIFO accepting HEADS pushes and delivering TAILS pops per clock
module fifo_mport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int HEADS    = 2,
  parameter int TAILS    = 2,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input logic clk,
  input logic rst,
  fifo_mport_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  if (DEPTH != (1 << AW) || DEPTH < HEADS || DEPTH < TAILS || HEADS < 1 || TAILS < 1) begin : g_bad_params
    $error("fifo_mport: DEPTH must be a power of 2 >= max(HEADS,TAILS), HEADS/TAILS >= 1");
  end
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_wptr, r_rptr, r_count;
  logic r_ovf, r_unf;
  logic [CW-1:0] w_free, w_npush, w_npop;
  logic [HEADS-1:0] w_rdy, w_acc;
  logic [TAILS-1:0] w_vld, w_hon;
  logic [AW-1:0] w_waddr [HEADS];
  logic w_run;
  assign w_free = CW'(DEPTH) - r_count;
  // accepted pushes pack into consecutive slots; pops honoured only as an unbroken run from port 0
  always_comb begin
    w_rdy = '0;
    w_acc = '0;
    w_npush = '0;
    w_waddr = '{default: '0};
    w_vld = '0;
    w_hon = '0;
    w_npop = '0;
    w_run = 1'b1;
    for (int h = 0; h < HEADS; h++) begin
      w_rdy[h] = w_free > CW'(h);
      w_acc[h] = bus.push[h] & w_rdy[h];
      w_waddr[h] = AW'(r_wptr + w_npush);
      w_npush = w_npush + CW'(w_acc[h]);
    end
    for (int t = 0; t < TAILS; t++) begin
      w_vld[t] = r_count > CW'(t);
      w_run = w_run & bus.pop[t] & w_vld[t];
      w_hon[t] = w_run;
      w_npop = w_npop + CW'(w_run);
    end
  end
  always_comb begin
    bus.doup = '0;
    for (int t = 0; t < TAILS; t++)
      bus.doup[t] = w_vld[t] ? r_mem[AW'(r_rptr + CW'(t))] : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (bus.flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_wptr <= r_wptr + w_npush;
      r_rptr <= r_rptr + w_npop;
      r_count <= r_count + w_npush - w_npop;
      r_ovf <= r_ovf | (|(bus.push & ~w_rdy));
      r_unf <= r_unf | (|(bus.pop & ~w_hon));
    end
  always_ff @(posedge clk)
    if (!bus.flush)
      for (int h = 0; h < HEADS; h++)
        if (w_acc[h]) r_mem[w_waddr[h]] <= bus.dinp[h];
  assign bus.push_rdy = w_rdy;
  assign bus.doup_vld = w_vld;
  assign bus.count = r_count;
  assign bus.free = w_free;
  assign bus.almost_full = r_count >= CW'(AF_LEVEL);
  assign bus.almost_empty = r_count <= CW'(AE_LEVEL);
  assign bus.ovf = r_ovf;
  assign bus.unf = r_unf;
  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst) r_count == CW'(r_wptr - r_rptr));
endmodule

// File: tb/tb_fifo_mport.sv
// tb_fifo_mport: random and directed traffic against a queue model with a pop scoreboard
module tb_fifo_mport;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_mport_if #(.WIDTH(32), .DEPTH(16), .HEADS(2), .TAILS(2)) bus ();
  fifo_mport #(.WIDTH(32), .DEPTH(16), .HEADS(2), .TAILS(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] sb [$];
  int mc, n_chk, n_fail, m_npush, m_npop;
  bit movf, munf;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic check_state();
    chk("count", 32'(bus.count), mc);
    chk("free", 32'(bus.free), 16 - mc);
    chk("push_rdy", 32'(bus.push_rdy), {30'd0, (16 - mc) > 1, (16 - mc) > 0});
    chk("doup_vld", 32'(bus.doup_vld), {30'd0, mc > 1, mc > 0});
    chk("doup0", bus.doup[0], mc > 0 ? sb[0] : 32'd0);
    chk("doup1", bus.doup[1], mc > 1 ? sb[1] : 32'd0);
    chk("almost_full", {31'd0, bus.almost_full}, {31'd0, mc >= 14});
    chk("almost_empty", {31'd0, bus.almost_empty}, {31'd0, mc <= 1});
    chk("ovf", {31'd0, bus.ovf}, {31'd0, movf});
    chk("unf", {31'd0, bus.unf}, {31'd0, munf});
  endtask
  // called at a falling edge: check, drive, advance the model, wait one cycle
  task automatic step(input logic [1:0] p, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] q, input logic f);
    int fr;
    bit run;
    check_state();
    bus.push = p;
    bus.dinp[0] = d0;
    bus.dinp[1] = d1;
    bus.pop = q;
    bus.flush = f;
    m_npush = 0;
    m_npop = 0;
    if (f) begin
      sb.delete();
      mc = 0;
      movf = 0;
      munf = 0;
    end else begin
      fr = 16 - mc;
      for (int i = 0; i < 2; i++)
        if (p[i]) begin
          if (fr > i) begin
            sb.push_back(i == 1 ? d1 : d0);
            m_npush++;
          end else movf = 1;
        end
      run = 1;
      for (int t = 0; t < 2; t++) begin
        run = run && q[t] && (mc > t);
        if (run) m_npop++;
        else if (q[t]) munf = 1;
      end
      mc = mc + m_npush - m_npop;
    end
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    bit run;
    int k;
    #2;
    if (!rst && !bus.flush) begin
      run = 1;
      k = 0;
      for (int t = 0; t < 2; t++) begin
        run = run && bus.pop[t] && bus.doup_vld[t];
        if (run) begin
          chk($sformatf("pop_data%0d", t), bus.doup[t], sb.size() > t ? sb[t] : 32'hdeadbeef);
          k++;
        end
      end
      repeat (k) if (sb.size() > 0) void'(sb.pop_front());
    end
  end
  initial begin
    int w, got;
    bus.push = '0;
    bus.dinp = '0;
    bus.pop = '0;
    bus.flush = 1'b0;
    #12;
    check_state();
    @(negedge clk);
    rst = 1'b0;
    step(2'b11, 32'hA, 32'hB, 2'b00, 1'b0);
    repeat (7) step(2'b11, $urandom, $urandom, 2'b00, 1'b0);
    step(2'b01, $urandom, $urandom, 2'b00, 1'b0);
    step(2'b00, 0, 0, 2'b01, 1'b0);
    step(2'b11, $urandom, $urandom, 2'b11, 1'b0);
    repeat (5) step(2'b00, 0, 0, 2'b11, 1'b0);
    step(2'b00, 0, 0, 2'b01, 1'b0);
    step(2'b00, 0, 0, 2'b10, 1'b0);
    step(2'b00, 0, 0, 2'b01, 1'b0);
    step(2'b00, 0, 0, 2'b00, 1'b1);
    w = 0;
    got = 0;
    for (int c = 0; c < 2000 && got < 40; c++) begin
      step({1'b0, w < 40 && $urandom_range(0, 1) == 1}, 32'h100 + w, $urandom,
           {1'b0, $urandom_range(0, 2) != 0}, 1'b0);
      w += m_npush;
      got += m_npop;
    end
    chk("drained_40", got, 40);
    for (int c = 0; c < 300; c++)
      step(2'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)),
           $urandom_range(0, 19) == 0);
    step(2'b00, 0, 0, 2'b00, 1'b1);
    repeat (8) step(2'b11, $urandom, $urandom, 2'b00, 1'b0);
    step(2'b01, $urandom, $urandom, 2'b00, 1'b0);
    repeat (3) step(2'b00, 0, 0, 2'b11, 1'b0);
    step(2'b00, 0, 0, 2'b01, 1'b0);
    step(2'b11, $urandom, $urandom, 2'b00, 1'b1);
    repeat (3) step(2'b11, $urandom, $urandom, 2'b00, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    mc = 0;
    movf = 0;
    munf = 0;
    check_state();
    bus.push = '0;
    @(negedge clk);
    rst = 1'b0;
    step(2'b11, 32'h11, 32'h22, 2'b00, 1'b0);
    step(2'b00, 0, 0, 2'b11, 1'b0);
    check_state();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
